ring_xfer_ctrl: RTL
===================

// Module: ring_xfer_ctrl
// PURPOSE
//  Per-L1A transfer sequencer between the ADC sample ring buffer and the event buffer.
//  For each pending L1A it loads the ring read address, then reads SAMP_MAX+1 samples of WORDS_PER_SAMP words each.
//  It stalls on ring-almost-empty and on event-buffer-almost-full, then pops the L1A FIFO.
//  Successor of the fixed 96-word/7-bit sequencer; word count, counter widths and the stall watchdog are now parameters or options.
// PARAMETERS
//  WORDS_PER_SAMP  96  words read per sample; legal range 2..2**SEQ_W
//  SEQ_W           7   width of the word counter
//  SMP_W           7   width of the sample counter and SAMP_MAX
//  TMO_W           16  watchdog counter width (used only with RING_XFER_TMO_EN)
// PORTS
//  CLK          in   1      system clock
//  RST_B        in   1      asynchronous reset, active low
//  L1A_BUF_MT   in   1      L1A FIFO empty
//  RING_AMT     in   1      ring buffer almost empty: not enough words for one sample
//  EVT_BUF_AFL  in   1      event buffer almost full
//  EVT_BUF_AMT  in   1      event buffer almost empty (resume threshold)
//  SAMP_MAX     in   SMP_W  index of the last sample; sampled in LOAD_ADDR
//  TMO_LIMIT    in   TMO_W  stall cycles allowed before abort (ignored without macro)
//  LD_ADDR      out  1      1-cycle pulse: load ring read pointer from L1A FIFO head
//  RD           out  1      ring read / event write strobe
//  WORD_LAST    out  1      high with RD on the final word of each sample
//  NXT_L1A      out  1      1-cycle pulse: pop L1A FIFO
//  XFER_ABORT   out  1      1-cycle pulse on watchdog abort (tied 0 without macro)
//  BUSY         out  1      high in every state except IDLE
//  SAMP_CNT     out  SMP_W  current sample index
//  EVT_STATE    out  4      state encoding, for status readback
// BEHAVIOUR
//  - Reset (RST_B low, async): state=IDLE, all 1-bit outputs 0, SAMP_CNT=all-ones, word counter 0.
//  - All outputs are registered and decoded from nextstate, so a strobe is valid in the same cycle as the state it belongs to.
//  - States (EVT_STATE code):
//    IDLE(0), LOAD_ADDR(1), W4DATA(2), INC_SAMP(3), READ(4), LAST(5), W4_EVT_AMT(6), NEXT_L1A(7), ABORT(8).
//  - IDLE: !L1A_BUF_MT -> LOAD_ADDR, otherwise stay. SAMP_CNT is held at all-ones.
//  - LOAD_ADDR: LD_ADDR=1, latch SAMP_MAX into an internal register, then -> W4DATA.
//  - W4DATA:
//    !RING_AMT & EVT_BUF_AFL -> W4_EVT_AMT; !RING_AMT & !EVT_BUF_AFL -> INC_SAMP; otherwise stay.
//  - W4_EVT_AMT: EVT_BUF_AMT -> INC_SAMP, otherwise stay.
//  - INC_SAMP: RD=1, SAMP_CNT+1 (wraps all-ones->0), word counter=0.
//    Next: READ, or LAST if WORDS_PER_SAMP==2.
//  - READ: RD=1, word counter+1. -> LAST once the counter reaches WORDS_PER_SAMP-2.
//  - LAST: RD=1, WORD_LAST=1. RD is high for exactly WORDS_PER_SAMP consecutive cycles per sample.
//  - Exits from LAST, in priority order:
//    SAMP_CNT==latched SAMP_MAX -> NEXT_L1A; EVT_BUF_AFL -> W4_EVT_AMT; RING_AMT -> W4DATA; otherwise -> INC_SAMP.
//    INC_SAMP with no bubble gives back-to-back samples.
//  - NEXT_L1A: NXT_L1A=1, then -> IDLE. An event therefore always ends with exactly one pop.
//  - AFL and AMT together: AFL wins. Stalls only begin at sample boundaries; a sample in progress is never split.
//  - SAMP_MAX=0: one sample per event. SAMP_MAX=all-ones: 2**SMP_W samples, SAMP_CNT wraps to all-ones.
//  - SAMP_MAX changes mid-event have no effect; the value latched in LOAD_ADDR is used.
//  - Reset asserted mid-event: immediate IDLE, no NXT_L1A pulse. The upstream FIFO is reset by the same net.
// CONFIGURATION
//  - RING_XFER_TMO_EN defined:
//    - Watchdog counts consecutive cycles spent in W4DATA or W4_EVT_AMT; it clears on leaving either state.
//    - Count reaching TMO_LIMIT (TMO_LIMIT!=0) -> ABORT: XFER_ABORT=1 for 1 cycle, then NEXT_L1A (pop the L1A), then IDLE.
//    - TMO_LIMIT=0 disables the watchdog.
//  - RING_XFER_TMO_EN undefined: no watchdog logic, ABORT is unreachable, XFER_ABORT is constant 0.
// TESTING
//  1. WORDS_PER_SAMP=96, SAMP_MAX=7, one L1A, RING_AMT=0, AFL=0
//     -> LD_ADDR x1, 768 contiguous RD, 8 WORD_LAST, NXT_L1A x1, BUSY drops.
//  2. Same setup, RING_AMT=1 after sample 2's LAST, for 20 cycles
//     -> RD gap of at least 20 cycles at the sample boundary, total RD still 768.
//  3. EVT_BUF_AFL=1 during sample 0, EVT_BUF_AMT=1 after 50 cycles
//     -> W4_EVT_AMT entered after sample 0's LAST; resumes INC_SAMP on AMT.
//  4. Two queued L1As, SAMP_MAX=0, WORDS_PER_SAMP=2
//     -> two events of 2 RD each, two NXT_L1A, 1 IDLE cycle between events.
//  5. RST_B low mid-READ -> all outputs 0 asynchronously, EVT_STATE=0, SAMP_CNT=0x7F; clean restart on release.
//  6. With RING_XFER_TMO_EN, TMO_LIMIT=100, RING_AMT held 1
//     -> XFER_ABORT at stall cycle 100, then NXT_L1A, then IDLE. Without the macro: remains in W4DATA.

Source files
------------

// File: rtl/ring_xfer_ctrl.sv
// Per-L1A transfer sequencer: ADC sample ring buffer -> event buffer.
// Optional stall watchdog enabled by defining RING_XFER_TMO_EN.
module ring_xfer_ctrl #(
    parameter int WORDS_PER_SAMP = 96,
    parameter int SEQ_W          = 7,
    parameter int SMP_W          = 7,
    parameter int TMO_W          = 16
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             L1A_BUF_MT,
    input  logic             RING_AMT,
    input  logic             EVT_BUF_AFL,
    input  logic             EVT_BUF_AMT,
    input  logic [SMP_W-1:0] SAMP_MAX,
    input  logic [TMO_W-1:0] TMO_LIMIT,
    output logic             LD_ADDR,
    output logic             RD,
    output logic             WORD_LAST,
    output logic             NXT_L1A,
    output logic             XFER_ABORT,
    output logic             BUSY,
    output logic [SMP_W-1:0] SAMP_CNT,
    output logic [3:0]       EVT_STATE
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_ADDR  = 4'd1,
        W4DATA     = 4'd2,
        INC_SAMP   = 4'd3,
        READ       = 4'd4,
        LAST       = 4'd5,
        W4_EVT_AMT = 4'd6,
        NEXT_L1A   = 4'd7,
        ABORT      = 4'd8
    } state_t;

    localparam logic [SEQ_W-1:0] LAST_READ_IDX = SEQ_W'(WORDS_PER_SAMP - 2);
    localparam logic [SMP_W-1:0] SAMP_ONES     = {SMP_W{1'b1}};

    state_t             state_reg, state_next;
    logic [SEQ_W-1:0]   word_cnt_reg, word_cnt_next;
    logic [SMP_W-1:0]   samp_cnt_reg, samp_cnt_next;
    logic [SMP_W-1:0]   samp_max_reg;
    logic               ld_addr_reg, ld_addr_next;
    logic               rd_reg, rd_next;
    logic               word_last_reg, word_last_next;
    logic               nxt_l1a_reg, nxt_l1a_next;
    logic               xfer_abort_reg, xfer_abort_next;
    logic               busy_reg, busy_next;
    logic               tmo_hit;

`ifdef RING_XFER_TMO_EN
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic               stall_next;

    // Counts consecutive stall cycles; value 1 in the first stall cycle.
    assign stall_next = (state_next == W4DATA) || (state_next == W4_EVT_AMT);
    assign tmo_cnt_next = !stall_next ? '0 :
                          (&tmo_cnt_reg) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
    assign tmo_hit = (TMO_LIMIT != '0) && (tmo_cnt_reg >= TMO_LIMIT);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) tmo_cnt_reg <= '0;
        else        tmo_cnt_reg <= tmo_cnt_next;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_LIMIT;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            samp_cnt_reg <= SAMP_ONES;
            samp_max_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            samp_cnt_reg <= samp_cnt_next;
            if (state_reg == LOAD_ADDR)
                samp_max_reg <= SAMP_MAX;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (!L1A_BUF_MT) state_next = LOAD_ADDR;
            LOAD_ADDR:  state_next = W4DATA;
            W4DATA: begin
                if (tmo_hit)           state_next = ABORT;
                else if (!RING_AMT)    state_next = EVT_BUF_AFL ? W4_EVT_AMT : INC_SAMP;
            end
            W4_EVT_AMT: begin
                if (tmo_hit)           state_next = ABORT;
                else if (EVT_BUF_AMT)  state_next = INC_SAMP;
            end
            INC_SAMP:   state_next = (WORDS_PER_SAMP == 2) ? LAST : READ;
            READ:       if (word_cnt_reg == LAST_READ_IDX) state_next = LAST;
            LAST: begin
                // Stalls are only entered here, so a sample is never split.
                if (samp_cnt_reg == samp_max_reg) state_next = NEXT_L1A;
                else if (EVT_BUF_AFL)             state_next = W4_EVT_AMT;
                else if (RING_AMT)                state_next = W4DATA;
                else                              state_next = INC_SAMP;
            end
            NEXT_L1A:   state_next = IDLE;
            ABORT:      state_next = NEXT_L1A;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs and counters decoded from state_next so they line up with their state.
    always_comb begin
        ld_addr_next    = (state_next == LOAD_ADDR);
        rd_next         = (state_next == INC_SAMP) || (state_next == READ) || (state_next == LAST);
        word_last_next  = (state_next == LAST);
        nxt_l1a_next    = (state_next == NEXT_L1A);
        xfer_abort_next = (state_next == ABORT);
        busy_next       = (state_next != IDLE);
        word_cnt_next   = word_cnt_reg;
        samp_cnt_next   = samp_cnt_reg;
        if (state_next == INC_SAMP) begin
            word_cnt_next = '0;
            samp_cnt_next = samp_cnt_reg + 1'b1;
        end else if (state_next == READ) begin
            word_cnt_next = word_cnt_reg + 1'b1;
        end else if (state_next == IDLE) begin
            samp_cnt_next = SAMP_ONES;
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            ld_addr_reg    <= 1'b0;
            rd_reg         <= 1'b0;
            word_last_reg  <= 1'b0;
            nxt_l1a_reg    <= 1'b0;
            xfer_abort_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            ld_addr_reg    <= ld_addr_next;
            rd_reg         <= rd_next;
            word_last_reg  <= word_last_next;
            nxt_l1a_reg    <= nxt_l1a_next;
            xfer_abort_reg <= xfer_abort_next;
            busy_reg       <= busy_next;
        end
    end

    assign LD_ADDR    = ld_addr_reg;
    assign RD         = rd_reg;
    assign WORD_LAST  = word_last_reg;
    assign NXT_L1A    = nxt_l1a_reg;
    assign XFER_ABORT = xfer_abort_reg;
    assign BUSY       = busy_reg;
    assign SAMP_CNT   = samp_cnt_reg;
    assign EVT_STATE  = state_reg;

endmodule
